// File: rtl/sram_write_arbiter.sv
// Round-robin write arbiter that binds ingress ports to SRAM banks, choosing the bank with the most free pages.
// Optional macro SRAM_ARB_RESERVE_EN keeps 8 pages of headroom per bank when deciding eligibility.
module sram_write_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int NUM_SRAMS = 8,
  localparam int PW = $clog2(NUM_PORTS),
  localparam int SW = $clog2(NUM_SRAMS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [NUM_PORTS*5-1:0]  req_pages,
  input  logic [NUM_PORTS-1:0]    eop,
  input  logic [NUM_SRAMS*8-1:0]  free_space,
  output logic [NUM_PORTS-1:0]    grant,
  output logic [NUM_PORTS*SW-1:0] grant_sram,
  output logic [NUM_PORTS-1:0]    port_bound,
  output logic [NUM_SRAMS-1:0]    sram_busy
);

`ifdef SRAM_ARB_RESERVE_EN
  localparam logic [8:0] RESERVE = 9'd8;
`else
  localparam logic [8:0] RESERVE = 9'd0;
`endif

  logic [NUM_PORTS-1:0][4:0]    pages_a;
  logic [NUM_SRAMS-1:0][7:0]    free_a;
  logic [NUM_PORTS-1:0][SW-1:0] bank_q;
  logic [NUM_PORTS-1:0]         grant_q;
  logic [NUM_PORTS-1:0]         bound_q;
  logic [NUM_SRAMS-1:0]         busy_q;
  logic [PW-1:0]                rr_ptr;

  logic [NUM_PORTS-1:0] cand;
  logic                 sel_found;
  logic [PW-1:0]        sel_port;
  logic [PW-1:0]        idx;
  logic [8:0]           need;
  logic                 best_found;
  logic [SW-1:0]        best_bank;
  logic [7:0]           best_free;
  logic                 do_grant;

  assign pages_a    = req_pages;
  assign free_a     = free_space;
  assign grant      = grant_q;
  assign grant_sram = bank_q;
  assign port_bound = bound_q;
  assign sram_busy  = busy_q;

  // Requests from ports that already own a bank are ignored; this also covers eop+req together.
  assign cand = req & ~bound_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_found = 1'b0;
    sel_port  = '0;
    idx       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!sel_found && cand[idx]) begin
        sel_found = 1'b1;
        sel_port  = idx;
      end
    end
  end

  // Largest free_space among eligible banks; strict '>' keeps the lowest index on ties.
  always_comb begin
    need       = {4'b0, pages_a[sel_port]} + 9'd1 + RESERVE;
    best_found = 1'b0;
    best_bank  = '0;
    best_free  = '0;
    for (int s = 0; s < NUM_SRAMS; s++) begin
      if (!busy_q[s] && ({1'b0, free_a[s]} >= need) &&
          (!best_found || free_a[s] > best_free)) begin
        best_found = 1'b1;
        best_bank  = SW'(s);
        best_free  = free_a[s];
      end
    end
  end

  assign do_grant = sel_found && best_found;

  // NOTE: sequential state uses non-blocking assignments only, so every bit sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      bound_q <= '0;
      busy_q  <= '0;
      bank_q  <= '0;
      rr_ptr  <= '0;
    end else begin
      grant_q <= '0;
      // Releases act on the bank recorded at bind time; grant_sram itself is left untouched.
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (eop[p] && bound_q[p]) begin
          bound_q[p]         <= 1'b0;
          busy_q[bank_q[p]]  <= 1'b0;
        end
      end
      // A granted bank was idle this cycle, so it can never collide with a release above.
      if (do_grant) begin
        grant_q[sel_port] <= 1'b1;
        bound_q[sel_port] <= 1'b1;
        busy_q[best_bank] <= 1'b1;
        bank_q[sel_port]  <= best_bank;
        rr_ptr            <= (sel_port == PW'(NUM_PORTS - 1)) ? '0 : sel_port + 1'b1;
      end
    end
  end

endmodule
